// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC DRP sampling path: FSM encoding,
// auxiliary-channel DRP addresses and the raw conversion width.
package xadc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } drp_state_e;

    localparam logic [6:0] VAUX6  = 7'h16;
    localparam logic [6:0] VAUX7  = 7'h17;
    localparam logic [6:0] VAUX14 = 7'h1E;
    localparam logic [6:0] VAUX15 = 7'h1F;

    localparam int unsigned RAW_W = 12;

    // Sample counter needs at least one bit even when no averaging is done.
    function automatic int unsigned cnt_width(input int unsigned avg_log2);
        return (avg_log2 == 0) ? 1 : avg_log2;
    endfunction

endpackage

// File: rtl/sample_averager.sv
// Accumulates 2^AVG_LOG2 raw conversions and emits their truncated mean
// with a one-cycle valid strobe; partial sums persist across idle periods.
module sample_averager
    import xadc_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw_valid_i,
    input  logic [RAW_W-1:0] raw_i,
    output logic [RAW_W-1:0] sample_o,
    output logic             sample_valid_o
);

    localparam int unsigned      ACC_W    = RAW_W + AVG_LOG2;
    localparam int unsigned      CNT_W    = cnt_width(AVG_LOG2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RAW_W-1:0] sample_q, sample_d;
    logic             valid_q, valid_d;

    always_comb begin
        sum      = acc_q + ACC_W'(raw_i);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        if (raw_valid_i) begin
            if (cnt_q == CNT_LAST) begin
                sample_d = RAW_W'(sum >> AVG_LOG2);
                valid_d  = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;

endmodule

// File: rtl/xadc_drp_sampler.sv
// Issues one DRP read of a fixed XADC channel per end-of-conversion and
// hands the averaged result to the filter datapath.
module xadc_drp_sampler
    import xadc_pkg::*;
#(
    parameter logic [6:0]  CHANNEL_ADDR = VAUX14,
    parameter int unsigned AVG_LOG2     = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        eoc_in,
    input  logic        drdy_in,
    input  logic [15:0] do_in,
    output logic        den_out,
    output logic [6:0]  daddr_out,
    output logic        dwe_out,
    output logic [11:0] sample_out,
    output logic [7:0]  sample8_out,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    drp_state_e  state_q;
    logic [15:0] timer_q;
    logic        den_q, busy_q, overrun_q, timeout_q;

    logic             raw_valid;
    logic [RAW_W-1:0] raw;
    logic             unused_lsbs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            den_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            den_q     <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (eoc_in) begin
                        state_q <= REQ;
                        den_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                REQ: begin
                    timer_q   <= '0;
                    state_q   <= WAIT;
                    overrun_q <= eoc_in;
                end
                WAIT: begin
                    overrun_q <= eoc_in;
                    // drdy takes priority over a timer expiring on the same edge
                    if (drdy_in) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (timer_q == TMO_LAST) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign raw_valid   = (state_q == WAIT) && drdy_in;
    assign raw         = do_in[15:4];
    assign unused_lsbs = ^do_in[3:0];

    sample_averager #(
        .AVG_LOG2(AVG_LOG2)
    ) u_averager (
        .clk           (clk),
        .rst_n         (rst_n),
        .raw_valid_i   (raw_valid),
        .raw_i         (raw),
        .sample_o      (sample_out),
        .sample_valid_o(sample_valid)
    );

    assign sample8_out = sample_out[11:4];
    assign den_out     = den_q;
    assign daddr_out   = CHANNEL_ADDR;
    assign dwe_out     = 1'b0;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Two sampler instances (no averaging / TIMEOUT 8, 4-sample averaging /
// TIMEOUT 4) share one DRP stimulus stream and are checked against a read-level model.
module tb_xadc_drp_sampler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eoc_in = 1'b0;
    logic        drdy_in = 1'b0;
    logic [15:0] do_in = '0;

    logic        den[2], dwe[2], sv[2], busy[2], ovr[2], tmo_err[2];
    logic [6:0]  daddr[2];
    logic [11:0] smp[2];
    logic [7:0]  smp8[2];

    int unsigned tmo_p[2]  = '{8, 4};
    int unsigned lg[2]     = '{0, 2};
    logic [6:0]  addr_p[2] = '{7'h1E, 7'h16};

    int n_checks = 0;
    int n_fail   = 0;

    // read-level model: sum and count of accepted raws, last published mean
    int unsigned m_sum[2], m_n[2];
    logic [11:0] m_sample[2];
    int          obs_valid[2], obs_tmo[2], obs_ovr[2];

    always #5 clk = ~clk;

    xadc_drp_sampler #(.CHANNEL_ADDR(7'h1E), .AVG_LOG2(0), .TIMEOUT(8)) u_a (
        .clk(clk), .rst_n(rst_n), .eoc_in(eoc_in), .drdy_in(drdy_in), .do_in(do_in),
        .den_out(den[0]), .daddr_out(daddr[0]), .dwe_out(dwe[0]),
        .sample_out(smp[0]), .sample8_out(smp8[0]), .sample_valid(sv[0]),
        .busy(busy[0]), .overrun(ovr[0]), .timeout_err(tmo_err[0]));

    xadc_drp_sampler #(.CHANNEL_ADDR(7'h16), .AVG_LOG2(2), .TIMEOUT(4)) u_b (
        .clk(clk), .rst_n(rst_n), .eoc_in(eoc_in), .drdy_in(drdy_in), .do_in(do_in),
        .den_out(den[1]), .daddr_out(daddr[1]), .dwe_out(dwe[1]),
        .sample_out(smp[1]), .sample8_out(smp8[1]), .sample_valid(sv[1]),
        .busy(busy[1]), .overrun(ovr[1]), .timeout_err(tmo_err[1]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sum[i]    = 0;
            m_n[i]      = 0;
            m_sample[i] = '0;
        end
    endtask

    // One conversion: eoc sampled at edge N, drdy (if k>=1) sampled at edge N+1+k,
    // optional extra eoc sampled at edge N+1+ovr_r. Checks every cycle until both idle.
    task automatic do_read(input int k, input logic [15:0] data, input int ovr_r);
        int         end_r[2];
        bit         ok[2];
        int         last;
        logic [4:0] exp_f, got_f;
        last = 0;
        for (int i = 0; i < 2; i++) begin
            ok[i]    = (k >= 1) && (k <= int'(tmo_p[i]));
            end_r[i] = 1 + (ok[i] ? k : int'(tmo_p[i]));
            if (end_r[i] > last) last = end_r[i];
        end
        eoc_in  = 1'b1;
        drdy_in = 1'b0;
        do_in   = 16'($urandom);
        for (int r = 0; r <= last; r++) begin
            tick();
            eoc_in  = (r == ovr_r);
            drdy_in = (k >= 1) && (r == k);
            do_in   = drdy_in ? data : 16'($urandom);
            for (int i = 0; i < 2; i++) begin
                exp_f = {r == 0, r < end_r[i], (r == end_r[i]) && !ok[i],
                         (ovr_r >= 0) && (r == ovr_r + 1) && (r <= end_r[i]), 1'b0};
                if (r == end_r[i] && ok[i]) begin
                    m_sum[i] += 32'(data[15:4]);
                    m_n[i]++;
                    if (m_n[i] == (32'd1 << lg[i])) begin
                        m_sample[i] = 12'(m_sum[i] >> lg[i]);
                        m_sum[i]    = 0;
                        m_n[i]      = 0;
                        exp_f[0]    = 1'b1;
                    end
                end
                got_f = {den[i], busy[i], tmo_err[i], ovr[i], sv[i]};
                if (sv[i] === 1'b1) obs_valid[i]++;
                if (tmo_err[i] === 1'b1) obs_tmo[i]++;
                if (ovr[i] === 1'b1) obs_ovr[i]++;
                n_checks++;
                if (got_f !== exp_f) begin
                    n_fail++;
                    $display("FAIL flags{den,busy,tmo,ovr,valid} dut%0d r=%0d k=%0d: got %b expected %b",
                             i, r, k, got_f, exp_f);
                end
                n_checks++;
                if ({smp[i], smp8[i]} !== {m_sample[i], m_sample[i][11:4]}) begin
                    n_fail++;
                    $display("FAIL sample dut%0d r=%0d: got %h/%h expected %h/%h",
                             i, r, smp[i], smp8[i], m_sample[i], m_sample[i][11:4]);
                end
            end
        end
        eoc_in  = 1'b0;
        drdy_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({den[i], dwe[i], sv[i], busy[i], ovr[i], tmo_err[i], smp[i], smp8[i]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got %b expected all zero",
                         i, {den[i], dwe[i], sv[i], busy[i], ovr[i], tmo_err[i], smp[i], smp8[i]});
            end
            n_checks++;
            if (daddr[i] !== addr_p[i]) begin
                n_fail++;
                $display("FAIL daddr dut%0d: got %h expected %h", i, daddr[i], addr_p[i]);
            end
        end
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_single_read();
        int v0;
        v0 = obs_valid[0];
        do_read(4, 16'hABC0, -1);
        n_checks++;
        if (obs_valid[0] - v0 != 1 || smp[0] !== 12'hABC || smp8[0] !== 8'hAB) begin
            n_fail++;
            $display("FAIL single_read: got valids=%0d sample=%h s8=%h expected 1/ABC/AB",
                     obs_valid[0] - v0, smp[0], smp8[0]);
        end
    endtask

    task automatic test_averaging();
        logic [11:0] raws[4] = '{12'h100, 12'h101, 12'h102, 12'h104};
        int v1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        v1 = obs_valid[1];
        for (int j = 0; j < 4; j++) begin
            do_read(int'($urandom_range(1, 4)), {raws[j], 4'($urandom)}, -1);
            if (j == 2) begin
                n_checks++;
                if (obs_valid[1] != v1) begin
                    n_fail++;
                    $display("FAIL avg_early_valid: got %0d valids expected 0", obs_valid[1] - v1);
                end
            end
        end
        n_checks++;
        if (obs_valid[1] - v1 != 1 || smp[1] !== 12'h101) begin
            n_fail++;
            $display("FAIL averaging: got valids=%0d sample=%h expected 1/101", obs_valid[1] - v1, smp[1]);
        end
    endtask

    task automatic test_timeout();
        int t0, t1;
        do_read(2, 16'h2220, -1);
        t0 = obs_tmo[0];
        t1 = obs_tmo[1];
        do_read(0, 16'h0000, -1);
        n_checks++;
        if (obs_tmo[0] - t0 != 1 || obs_tmo[1] - t1 != 1) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d/%0d expected 1/1", obs_tmo[0] - t0, obs_tmo[1] - t1);
        end
        for (int j = 0; j < 3; j++) do_read(1, 16'($urandom), -1);
    endtask

    task automatic test_overrun();
        int o0, o1;
        o0 = obs_ovr[0];
        o1 = obs_ovr[1];
        do_read(3, 16'h7770, 1);
        do_read(2, 16'h8880, 0);
        n_checks++;
        if (obs_ovr[0] - o0 != 2 || obs_ovr[1] - o1 != 2) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d/%0d expected 2/2", obs_ovr[0] - o0, obs_ovr[1] - o1);
        end
    endtask

    task automatic test_collision();
        int t0, t1, v0;
        t0 = obs_tmo[0];
        t1 = obs_tmo[1];
        v0 = obs_valid[0];
        do_read(4, 16'h4440, -1);
        do_read(8, 16'h9990, -1);
        n_checks++;
        if (obs_tmo[0] - t0 != 0 || obs_tmo[1] - t1 != 1 || obs_valid[0] - v0 != 2) begin
            n_fail++;
            $display("FAIL collision: got tmoA=%0d tmoB=%0d validA=%0d expected 0/1/2",
                     obs_tmo[0] - t0, obs_tmo[1] - t1, obs_valid[0] - v0);
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 8; j++) do_read(1, 16'($urandom), -1);
    endtask

    task automatic test_reset_mid_read();
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({den[i], sv[i], busy[i], ovr[i], tmo_err[i], smp[i], smp8[i]} !== '0) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got %b expected all zero",
                         i, {den[i], sv[i], busy[i], ovr[i], tmo_err[i], smp[i], smp8[i]});
            end
        end
        model_reset();
        tick();
        rst_n   = 1'b1;
        drdy_in = 1'b1;
        do_in   = 16'hFFF0;
        tick();
        drdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({busy[i], sv[i], smp[i]} !== '0) begin
                n_fail++;
                $display("FAIL stray_drdy dut%0d: got busy=%b valid=%b sample=%h expected 0/0/000",
                         i, busy[i], sv[i], smp[i]);
            end
        end
        tick();
        do_read(2, 16'h5A50, -1);
    endtask

    task automatic test_random();
        int k, me, ov;
        for (int j = 0; j < 40; j++) begin
            k  = int'($urandom_range(0, 10));
            me = 1 + ((k >= 1 && k <= 4) ? k : 4);
            ov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, me - 1)) : -1;
            do_read(k, 16'($urandom), ov);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            obs_valid[i] = 0;
            obs_tmo[i]   = 0;
            obs_ovr[i]   = 0;
        end
        model_reset();
        test_reset();
        test_single_read();
        test_averaging();
        test_timeout();
        test_overrun();
        test_collision();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
